// File: rtl/rx_os_consecutive_counter_pkg.sv
// Shared definitions for the RX ordered-set consecutive counter bank.
// Holds the lane FSM state encoding, the default counter width, and the
// ordered-set type codes the lane decoders use to build osMatch.
// Optional feature macro: RX_OS_IDENT_CHECK_EN (consecutive identical TS check).
package rx_os_consecutive_counter_pkg;

  // Per-lane counter FSM encoding
  typedef enum logic [1:0] {
    LANE_DISARMED = 2'd0,
    LANE_COUNT    = 2'd1,
    LANE_DONE     = 2'd2
  } lane_state_e;

  localparam int CNT_W_DEFAULT = 5;
  localparam int TARGET_W      = 5;
  localparam int PAYLOAD_W     = 8;

  // Ordered-set type codes reported by the lane OS decoders
  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_EIOS = 3'd3,
    OS_EQ   = 3'd4
  } os_type_e;

`ifdef RX_OS_IDENT_CHECK_EN
  localparam bit IDENT_CHECK_EN = 1'b1;
`else
  localparam bit IDENT_CHECK_EN = 1'b0;
`endif

  // True when a received OS is the type the current LTSSM substate expects
  function automatic logic os_type_match(input os_type_e rcvd, input os_type_e expected);
    return (rcvd == expected) && (rcvd != OS_NONE);
  endfunction

endpackage

// File: rtl/rx_os_consecutive_counter_lane.sv
// rx_os_lane_counter: one lane's consecutive ordered-set counter.
// Ports:
//   clk_i, rst_n_i   core clock, synchronous active-low reset
//   arm_i            1 = counting enabled, 0 = lane cleared (DISARMED)
//   target_i         required number of consecutive matching OSs
//   os_valid_i       one complete OS received this cycle
//   os_match_i       the OS is of the expected type
//   payload_i        link/lane-number symbol (only with RX_OS_IDENT_CHECK_EN)
//   done_o           registered sticky "target reached" flag
//   count_o          current consecutive count (saturating)
module rx_os_lane_counter
  import rx_os_consecutive_counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 arm_i,
  input  logic [TARGET_W-1:0]  target_i,
  input  logic                 os_valid_i,
  input  logic                 os_match_i,
`ifdef RX_OS_IDENT_CHECK_EN
  input  logic [PAYLOAD_W-1:0] payload_i,
`endif
  output logic                 done_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lane_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d, payload_s;
  logic                   payload_vld_q, payload_vld_d;
  logic [CNT_W-1:0]       target_ext_s;

  // Counter never wraps: it parks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

`ifdef RX_OS_IDENT_CHECK_EN
  assign payload_s = payload_i;
`else
  assign payload_s = {PAYLOAD_W{1'b0}};
`endif

  assign target_ext_s = CNT_W'(target_i);

  // Next counter value and payload latch for a counting lane
  always_comb begin
    cnt_d         = cnt_q;
    payload_d     = payload_q;
    payload_vld_d = payload_vld_q;
    if (os_valid_i && os_match_i) begin
      // A different link/lane symbol starts a new run; this OS is its first member
      if (IDENT_CHECK_EN && payload_vld_q && (payload_s != payload_q)) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
      payload_d     = payload_s;
      payload_vld_d = 1'b1;
    end else if (os_valid_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Lane FSM, counter and sticky flag; disarm overrides everything but reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !arm_i) begin
      state_q       <= LANE_DISARMED;
      cnt_q         <= {CNT_W{1'b0}};
      done_q        <= 1'b0;
      payload_q     <= {PAYLOAD_W{1'b0}};
      payload_vld_q <= 1'b0;
    end else begin
      case (state_q)
        LANE_DISARMED: begin
          // Arm cycle: strobes in this cycle are deliberately dropped
          state_q       <= LANE_COUNT;
          cnt_q         <= {CNT_W{1'b0}};
          done_q        <= 1'b0;
          payload_q     <= {PAYLOAD_W{1'b0}};
          payload_vld_q <= 1'b0;
        end
        LANE_COUNT: begin
          cnt_q         <= cnt_d;
          payload_q     <= payload_d;
          payload_vld_q <= payload_vld_d;
          // Compared against the registered count, so the flag trails the strobe by one edge
          if (cnt_q >= target_ext_s) begin
            state_q <= LANE_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= LANE_COUNT;
            done_q  <= 1'b0;
          end
        end
        LANE_DONE: begin
          cnt_q         <= cnt_d;
          payload_q     <= payload_d;
          payload_vld_q <= payload_vld_d;
          state_q       <= LANE_DONE;
          done_q        <= 1'b1;
        end
        default: begin
          state_q       <= LANE_DISARMED;
          cnt_q         <= {CNT_W{1'b0}};
          done_q        <= 1'b0;
          payload_q     <= {PAYLOAD_W{1'b0}};
          payload_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign done_o  = done_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/rx_os_consecutive_counter.sv
// rx_os_consecutive_counter: per-lane bank of consecutive ordered-set
// counters feeding the master RX LTSSM.
// Ports:
//   clk                  core clock
//   reset                synchronous active-low reset
//   resetOsCheckers      per-lane arm (1 = count, 0 = clear)
//   comparatorsCount     required consecutive matching OS count
//   osValid / osMatch    per-lane OS strobe and type qualifier
//   osPayload            per-lane link/lane symbol (only with RX_OS_IDENT_CHECK_EN)
//   countersComparators  per-lane sticky "target reached" flag
//   laneCount            per-lane count, lane i at [i*CNT_W +: CNT_W]
// Optional feature macro: RX_OS_IDENT_CHECK_EN.
module rx_os_consecutive_counter
  import rx_os_consecutive_counter_pkg::*;
#(
  parameter int MAXLANES = 16,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MAXLANES-1:0]       resetOsCheckers,
  input  logic [TARGET_W-1:0]       comparatorsCount,
  input  logic [MAXLANES-1:0]       osValid,
  input  logic [MAXLANES-1:0]       osMatch,
`ifdef RX_OS_IDENT_CHECK_EN
  input  logic [MAXLANES*8-1:0]     osPayload,
`endif
  output logic [MAXLANES-1:0]       countersComparators,
  output logic [MAXLANES*CNT_W-1:0] laneCount
);

  for (genvar g = 0; g < MAXLANES; g++) begin : g_lane
    rx_os_lane_counter #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk_i      (clk),
      .rst_n_i    (reset),
      .arm_i      (resetOsCheckers[g]),
      .target_i   (comparatorsCount),
      .os_valid_i (osValid[g]),
      .os_match_i (osMatch[g]),
`ifdef RX_OS_IDENT_CHECK_EN
      .payload_i  (osPayload[g*8 +: 8]),
`endif
      .done_o     (countersComparators[g]),
      .count_o    (laneCount[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_rx_os_consecutive_counter.sv
module tb_rx_os_consecutive_counter;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  resetOsCheckers;
  logic [4:0]   comparatorsCount;
  logic [15:0]  osValid;
  logic [15:0]  osMatch;
  logic [127:0] osPayload;
  logic [15:0]  countersComparators;
  logic [79:0]  laneCount;

  typedef struct packed {
    logic [15:0] flags;
    logic [79:0] lc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  rx_os_consecutive_counter #(.MAXLANES(16), .CNT_W(5)) dut (
    .clk                 (clk),
    .reset               (reset),
    .resetOsCheckers     (resetOsCheckers),
    .comparatorsCount    (comparatorsCount),
    .osValid             (osValid),
    .osMatch             (osMatch),
`ifdef RX_OS_IDENT_CHECK_EN
    .osPayload           (osPayload),
`endif
    .countersComparators (countersComparators),
    .laneCount           (laneCount)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] lc0(input int c);
    logic [79:0] v;
    v = '0;
    v[4:0] = 5'(c);
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [15:0] arm, input logic [15:0] vld,
                       input logic [15:0] mat, input logic [4:0] tgt);
    reset            = rst;
    resetOsCheckers  = arm;
    osValid          = vld;
    osMatch          = mat;
    comparatorsCount = tgt;
  endtask

  task automatic push(input logic [15:0] flags, input logic [79:0] lc);
    exp_t x;
    x.flags = flags;
    x.lc    = lc;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd0);
      push(16'h0, 80'h0);
      tick();
      e = exp_q.pop_front();
      vec_cnt++;
      if (countersComparators !== e.flags || laneCount !== e.lc) begin
        err_cnt++;
        $display("FAIL reset[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", i, countersComparators, laneCount, e.flags, e.lc);
      end
    end
    drive(1'b1, 16'h0, 16'h0, 16'h0, 5'd0);
    push(16'h0, 80'h0);
    tick();
    e = exp_q.pop_front();
    vec_cnt++;
    if (countersComparators !== e.flags || laneCount !== e.lc) begin
      err_cnt++;
      $display("FAIL reset_release: got flags=%h lc=%h, want flags=%h lc=%h", countersComparators, laneCount, e.flags, e.lc);
    end
  endtask

  // Arm lane 0 with a strobe on the arm cycle (ignored), 8 matches, flag one edge later
  task automatic test_basic();
    drive(1'b1, 16'h0001, 16'h0001, 16'h0001, 5'd8);
    push(16'h0, lc0(0));
    for (int k = 1; k <= 8; k++) push(16'h0, lc0(k));
    push(16'h0001, lc0(8));
    push(16'h0001, lc0(0));
    push(16'h0, lc0(0));
    for (int s = 0; s < 12; s++) begin
      if (s == 9)       drive(1'b1, 16'h0001, 16'h0, 16'h0, 5'd8);
      else if (s == 10) drive(1'b1, 16'h0001, 16'h0001, 16'h0, 5'd8);
      else if (s == 11) drive(1'b1, 16'h0, 16'h0, 16'h0, 5'd8);
      else              drive(1'b1, 16'h0001, 16'h0001, 16'h0001, 5'd8);
      tick();
      e = exp_q.pop_front();
      vec_cnt++;
      if (countersComparators !== e.flags || laneCount !== e.lc) begin
        err_cnt++;
        $display("FAIL basic[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", s, countersComparators, laneCount, e.flags, e.lc);
      end
    end
  endtask

  // 5 matches, 1 mismatch, 8 matches: flag only after the final run reaches 8
  task automatic test_mismatch();
    logic [15:0] vld, mat;
    int c;
    drive(1'b1, 16'h0001, 16'h0, 16'h0, 5'd8);
    push(16'h0, lc0(0));
    tick();
    e = exp_q.pop_front();
    vec_cnt++;
    if (countersComparators !== e.flags || laneCount !== e.lc) begin
      err_cnt++;
      $display("FAIL mismatch_arm: got flags=%h lc=%h, want flags=%h lc=%h", countersComparators, laneCount, e.flags, e.lc);
    end
    c = 0;
    for (int s = 0; s < 15; s++) begin
      vld = (s < 14) ? 16'h0001 : 16'h0;
      mat = (s == 5) ? 16'h0 : 16'h0001;
      drive(1'b1, 16'h0001, vld, mat, 5'd8);
      if (s == 5) c = 0;
      else if (s < 14) c++;
      push((s == 14) ? 16'h0001 : 16'h0, lc0(c));
      tick();
      e = exp_q.pop_front();
      vec_cnt++;
      if (countersComparators !== e.flags || laneCount !== e.lc) begin
        err_cnt++;
        $display("FAIL mismatch[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", s, countersComparators, laneCount, e.flags, e.lc);
      end
    end
    drive(1'b1, 16'h0, 16'h0, 16'h0, 5'd8);
    tick();
  endtask

  // Target 0: lanes 0-3 flag two edges after arm; raising the target keeps DONE
  task automatic test_zero_target();
    push(16'h0, 80'h0);
    push(16'h000F, 80'h0);
    push(16'h000F, 80'h0);
    push(16'h0, 80'h0);
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, (s == 3) ? 16'h0 : 16'h000F, 16'h0, 16'h0, (s == 2) ? 5'd31 : 5'd0);
      tick();
      e = exp_q.pop_front();
      vec_cnt++;
      if (countersComparators !== e.flags || laneCount !== e.lc) begin
        err_cnt++;
        $display("FAIL zero_target[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", s, countersComparators, laneCount, e.flags, e.lc);
      end
    end
  endtask

  // 40 matches against target 31: count parks at 31, flag after the edge following the 31st
  task automatic test_saturate();
    drive(1'b1, 16'h0001, 16'h0001, 16'h0001, 5'd31);
    push(16'h0, lc0(0));
    tick();
    e = exp_q.pop_front();
    vec_cnt++;
    if (countersComparators !== e.flags || laneCount !== e.lc) begin
      err_cnt++;
      $display("FAIL sat_arm: got flags=%h lc=%h, want flags=%h lc=%h", countersComparators, laneCount, e.flags, e.lc);
    end
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, 16'h0001, 16'h0001, 16'h0001, 5'd31);
      push((k >= 32) ? 16'h0001 : 16'h0, lc0((k > 31) ? 31 : k));
      tick();
      e = exp_q.pop_front();
      vec_cnt++;
      if (countersComparators !== e.flags || laneCount !== e.lc) begin
        err_cnt++;
        $display("FAIL saturate[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", k, countersComparators, laneCount, e.flags, e.lc);
      end
    end
    drive(1'b1, 16'h0, 16'h0, 16'h0, 5'd31);
    tick();
  endtask

  // All 16 lanes armed, lane i starts strobing at cycle i; then reset mid-count
  task automatic test_all_lanes();
    logic [15:0] vld, fl;
    logic [79:0] lc;
    drive(1'b1, 16'hFFFF, 16'h0, 16'h0, 5'd3);
    push(16'h0, 80'h0);
    tick();
    e = exp_q.pop_front();
    vec_cnt++;
    if (countersComparators !== e.flags || laneCount !== e.lc) begin
      err_cnt++;
      $display("FAIL lanes_arm: got flags=%h lc=%h, want flags=%h lc=%h", countersComparators, laneCount, e.flags, e.lc);
    end
    for (int c = 0; c < 20; c++) begin
      vld = '0;
      fl  = '0;
      lc  = '0;
      for (int i = 0; i < 16; i++) begin
        vld[i] = (c >= i);
        fl[i]  = (c >= i + 3);
        lc[i*5 +: 5] = (c >= i) ? 5'(c - i + 1) : 5'd0;
      end
      drive(1'b1, 16'hFFFF, vld, 16'hFFFF, 5'd3);
      push(fl, lc);
      tick();
      e = exp_q.pop_front();
      vec_cnt++;
      if (countersComparators !== e.flags || laneCount !== e.lc) begin
        err_cnt++;
        $display("FAIL lanes[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", c, countersComparators, laneCount, e.flags, e.lc);
      end
    end
    drive(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd3);
    push(16'h0, 80'h0);
    tick();
    e = exp_q.pop_front();
    vec_cnt++;
    if (countersComparators !== e.flags || laneCount !== e.lc) begin
      err_cnt++;
      $display("FAIL reset_mid: got flags=%h lc=%h, want flags=%h lc=%h", countersComparators, laneCount, e.flags, e.lc);
    end
    drive(1'b1, 16'h0, 16'h0, 16'h0, 5'd3);
    tick();
  endtask

`ifdef RX_OS_IDENT_CHECK_EN
  // Payload sequences on lane 0 with target 2
  task automatic test_ident();
    logic [7:0] pl [0:1][0:2];
    int         ce [0:1][0:2];
    int         n  [0:1];
    pl[0][0] = 8'h05; pl[0][1] = 8'h05; pl[0][2] = 8'h00;
    pl[1][0] = 8'h05; pl[1][1] = 8'h06; pl[1][2] = 8'h06;
    ce[0][0] = 1; ce[0][1] = 2; ce[0][2] = 0;
    ce[1][0] = 1; ce[1][1] = 1; ce[1][2] = 2;
    n[0] = 2;
    n[1] = 3;
    for (int t = 0; t < 2; t++) begin
      osPayload = '0;
      drive(1'b1, 16'h0001, 16'h0, 16'h0, 5'd2);
      tick();
      for (int s = 0; s <= n[t]; s++) begin
        if (s < n[t]) begin
          osPayload[7:0] = pl[t][s];
          drive(1'b1, 16'h0001, 16'h0001, 16'h0001, 5'd2);
          push(16'h0, lc0(ce[t][s]));
        end else begin
          drive(1'b1, 16'h0001, 16'h0, 16'h0, 5'd2);
          push(16'h0001, lc0(ce[t][s-1]));
        end
        tick();
        e = exp_q.pop_front();
        vec_cnt++;
        if (countersComparators !== e.flags || laneCount !== e.lc) begin
          err_cnt++;
          $display("FAIL ident%0d[%0d]: got flags=%h lc=%h, want flags=%h lc=%h", t, s, countersComparators, laneCount, e.flags, e.lc);
        end
      end
      drive(1'b1, 16'h0, 16'h0, 16'h0, 5'd2);
      tick();
    end
  endtask
`endif

  initial begin
    osPayload = '0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 5'd0);
    tick();
    test_reset();
    test_basic();
    test_mismatch();
    test_zero_target();
    test_saturate();
    test_all_lanes();
`ifdef RX_OS_IDENT_CHECK_EN
    test_ident();
`endif
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rx_os_consecutive_counter.md
Name: rx_os_consecutive_counter

Overview:
- Per-lane bank of ordered-set (TS1/TS2/EIOS/EQ) consecutive-receive counters; sits directly upstream of the master RX LTSSM.
- Consumes per-lane "OS received / OS matches expected" strobes from the lane OS decoders.
- Produces the per-lane countersComparators vector the LTSSM compares against its lane mask.
- Per-lane arm/clear is the LTSSM's resetOsCheckers; the target count is the LTSSM's comparatorsCount.

Parameters:
- MAXLANES, 16, number of lanes; width of every per-lane vector.
- CNT_W, 5, counter width; must be >= width of comparatorsCount.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- resetOsCheckers  input  MAXLANES  per-lane arm: 1 = counting enabled, 0 = lane cleared.
- comparatorsCount  input  5  required number of consecutive matching OSs.
- osValid  input  MAXLANES  per-lane strobe: one complete OS received this cycle.
- osMatch  input  MAXLANES  qualifies osValid: OS is the type expected by current substate.
- countersComparators  output  MAXLANES  per-lane sticky "target reached" flag.
- laneCount  output  MAXLANES*CNT_W  per-lane current consecutive count; lane i at [i*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low (reset).
- Reset (reset==0 at clk edge): all counters 0, all lane FSMs DISARMED, countersComparators=0, laneCount=0.
- Per-lane FSM, states DISARMED, COUNT, DONE. All transitions on clk edge.
  - resetOsCheckers[i]==0: lane i goes to DISARMED and its counter clears. Highest priority after reset.
  - DISARMED, resetOsCheckers[i]==1: -> COUNT, counter 0. OS strobes in that same cycle are ignored (one-cycle arm latency).
  - COUNT, osValid&osMatch: counter+1, saturating at 2^CNT_W-1.
  - COUNT, osValid&!osMatch: counter -> 0 (consecutive rule broken).
  - COUNT, !osValid: counter holds.
  - COUNT -> DONE when (counter >= comparatorsCount), evaluated on the registered counter each cycle.
  - DONE: sticky until resetOsCheckers[i]==0. Counter keeps updating per the COUNT rules, but the flag does not drop on a mismatch.
- countersComparators[i]=1 iff lane i in DONE. Registered output.
- Latency: the OS strobe that makes counter==target is at edge N. The counter updates at N. The flag is set at edge N+1.
- comparatorsCount==0: flag sets the cycle after entering COUNT, with no OS needed (detect states).
- comparatorsCount changed mid-count: compared live; a lane already in DONE stays DONE.
- Saturation: counter never wraps; with target <= 31 the flag is unaffected.
- Lanes are fully independent; lanes not in the LTSSM mask still count, and the LTSSM ignores them.
- Reset mid-operation: immediate clear regardless of state; no partial counts retained.

Optional Feature:
- Macro: RX_OS_IDENT_CHECK_EN.
- With it defined:
  - Adds input osPayload (MAXLANES*8): the link/lane-number symbol of each OS.
  - A matching OS whose payload differs from the previously latched payload of that lane restarts the counter at 1 (not 0) and latches the new payload.
  - The first OS after arm latches without a restart.
  - Implements the "consecutive identical TS" requirement.
- Without it: the port is absent; the payload is not checked; behaviour is as above.

Decomposition:
- Shared package:
  - lane FSM state encoding (DISARMED=2'd0, COUNT=2'd1, DONE=2'd2);
  - CNT_W default;
  - OS type codes used to build osMatch.
- Sub-module rx_os_lane_counter: one lane's FSM, counter and optional payload latch, generated MAXLANES times. The top level only slices vectors.

Test Plan:
- Arm lane 0 (resetOsCheckers=16'h0001), comparatorsCount=8, 8 consecutive osValid&osMatch strobes -> countersComparators[0] rises exactly 1 cycle after the 8th strobe; laneCount[0]=8.
- comparatorsCount=8: 5 matches, 1 mismatch, 8 matches -> laneCount sequence 5,0,...,8; flag set only after the final 8th match.
- comparatorsCount=0: arm lanes 0-3 -> countersComparators=16'h000F two cycles after resetOsCheckers rises, with no OS strobes.
- Lane in DONE, then a mismatch -> flag stays 1. Drop resetOsCheckers[0] -> flag and laneCount[0] are 0 next cycle. reset=0 mid-count on all 16 lanes -> all outputs 0 next cycle.
- osValid on the arm cycle is ignored, and 40 matches saturate the counter at 31 without wrap; x16 all lanes armed with staggered strobes -> each flag independent.
- RX_OS_IDENT_CHECK_EN: target 2, payloads 0x05,0x05 -> flag set. Payloads 0x05,0x06,0x06 -> counter 1,1,2, flag set after the third OS.
